// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / redirect flush controller for the 5-stage RV32 pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic                  ex_redirect,
  output logic                  muxsel,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       w_load_use;
  logic       w_muxsel, w_pc_write, w_if_id_write, w_if_id_flush;

  assign w_load_use = idex_memread && (idex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                       (id_use_rs2 && (id_rs2 == idex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_muxsel      = 1'b1;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    if (rst) begin
      w_muxsel      = 1'b0;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_if_id_flush = 1'b1;
    end else if (ex_redirect || (r_state == ST_FLUSH)) begin
      // Redirect wins in every state; FLUSH shares the same outputs.
      w_muxsel      = 1'b0;
      w_if_id_flush = 1'b1;
      if (ex_redirect) begin
        if (FLUSH_CYCLES > 1) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = FLUSH_RELOAD;
        end else begin
          w_state_next = ST_RUN;
          w_cnt_next   = 3'd0;
        end
      end else if (r_cnt <= 3'd1) begin
        w_state_next = ST_RUN;
        w_cnt_next   = 3'd0;
      end else begin
        w_cnt_next = r_cnt - 3'd1;
      end
    end else if ((r_state == ST_STALL) || w_load_use) begin
      w_muxsel      = 1'b0;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      if (r_state == ST_RUN) begin
        if (LOAD_STALL_CYCLES > 1) begin
          w_state_next = ST_STALL;
          w_cnt_next   = STALL_RELOAD;
        end
      end else if (r_cnt <= 3'd1) begin
        // cnt==0 here is illegal and also drops back to RUN.
        w_state_next = ST_RUN;
        w_cnt_next   = 3'd0;
      end else begin
        w_cnt_next = r_cnt - 3'd1;
      end
    end else if (r_state != ST_RUN) begin
      w_state_next = ST_RUN;
      w_cnt_next   = 3'd0;
    end
  end

  assign muxsel      = w_muxsel;
  assign pc_write    = w_pc_write;
  assign if_id_write = w_if_id_write;
  assign if_id_flush = w_if_id_flush;
  assign busy        = (r_state != ST_RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_cycles <= 32'd0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_if_id_flush && (r_flush_cycles != 32'hFFFF_FFFF))
        r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule
